dpram_port_arbiter: RTL
=======================

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 Parameter DW, default 8, data width of the shared RAM.
REQ-002 Parameter AW, default 4, address width of the shared RAM (16 locations).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester access request, held until granted.
REQ-006 we  input  4  per-requester write (1) / read (0) qualifier, valid with req.
REQ-007 addr  input  4*AW  packed per-requester address, requester i at bits [i*AW +: AW].
REQ-008 wdata  input  4*DW  packed per-requester write data.
REQ-009 gnt  output  4  combinational grant; transfer occurs on the rising edge where req[i]&gnt[i]=1.
REQ-010 rvalid  output  4  registered one-cycle read-return strobe per requester.
REQ-011 rdata  output  4*DW  packed registered read data, valid only where rvalid[i]=1.
REQ-012 ram_wr_en_a / ram_wr_en_b  output  1 each  RAM port write enables.
REQ-013 ram_addr_a / ram_addr_b  output  AW each  RAM port addresses.
REQ-014 ram_in_a / ram_in_b  output  DW each  RAM port write data.
REQ-015 ram_out_a / ram_out_b  input  DW each  RAM registered read data (valid one cycle after the port command).

Function
REQ-016 Round-robin pointer ptr (2 bits) sets scan order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-017 First requester in scan order with req=1 is granted port A.
REQ-018 Next requester in scan order with req=1 is granted port B unless it conflicts with port A; a conflicting candidate is skipped and scanning continues.
REQ-019 Conflict: same address and at least one of the two is a write; two reads of the same address do not conflict.
REQ-020 At most one gnt bit per port per cycle; gnt never asserts for req=0.
REQ-021 On any grant, ptr updates to (index of last granted requester + 1) mod 4; with no grant ptr holds.
REQ-022 Port command registered on the transfer edge: ram_wr_en_x=we, ram_addr_x=addr, ram_in_x=wdata of the granted requester.
REQ-023 Port with no grant in a cycle drives ram_wr_en_x=0 next cycle; ram_addr_x and ram_in_x retain previous values.
REQ-024 Read latency: read transferred on edge N -> RAM samples at edge N+1 -> rvalid[i]=1 with rdata[i]=ram_out_x for exactly the cycle after edge N+2.
REQ-025 Per-port two-stage tag pipeline (valid + 2-bit requester id) routes ram_out_x to the correct requester; writes produce no rvalid.
REQ-026 Fully pipelined: new grants every cycle; two reads for different requesters may return in the same cycle.
REQ-027 Same requester is never granted both ports in one cycle.

Reset
REQ-028 rst_n=0 asynchronously clears ptr, both tag pipelines, rvalid, rdata, ram_wr_en_a/b, ram_addr_a/b, ram_in_a/b to 0.
REQ-029 gnt is forced to 0 while rst_n=0.
REQ-030 Reads in flight when reset asserts are discarded; no rvalid is issued for them after release.
REQ-031 First grant after release starts scanning at requester 0.

Verification
REQ-032 Single write then read: req0 write addr 3 data 0xA5, then req0 read addr 3 -> gnt0 each cycle, ram_wr_en_a=1 for the write, rvalid[0]=1 with rdata=0xA5 two cycles after the read transfer.
REQ-033 All four read different addresses continuously from reset -> grants {0,1}, {2,3}, {0,1}, ...; each requester gets one rvalid every two cycles.
REQ-034 Write-write conflict: req1 and req2 both write addr 5 (0x11, 0x22), ptr=1 -> cycle 1 grants only req1 on port A; next cycle grants req2; final read of addr 5 returns 0x22.
REQ-035 Read-read same address: req0 and req3 read addr 7 (holding 0x3C) -> both granted same cycle, both rvalid with 0x3C same cycle.
REQ-036 Reset mid-operation: assert rst_n=0 one cycle after a read transfer -> no rvalid after release, all RAM-side outputs 0, next grant to lowest-index requester.
REQ-037 Idle: req=0 for 10 cycles -> gnt=0, rvalid=0, ram_wr_en_a/b=0, ptr unchanged throughout.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter mapping four requesters onto the two ports of a dual-port RAM,
// with a per-port tag pipeline that routes registered read data back to its requester.
module dpram_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      rvalid,
  output logic [4*DW-1:0] rdata,
  output logic            ram_wr_en_a,
  output logic            ram_wr_en_b,
  output logic [AW-1:0]   ram_addr_a,
  output logic [AW-1:0]   ram_addr_b,
  output logic [DW-1:0]   ram_in_a,
  output logic [DW-1:0]   ram_in_b,
  input  logic [DW-1:0]   ram_out_a,
  input  logic [DW-1:0]   ram_out_b
);

  // Two accesses collide on the same location unless both are reads.
  function automatic logic conflict(input logic [AW-1:0] addr_x, input logic we_x,
                                    input logic [AW-1:0] addr_y, input logic we_y);
    return (addr_x == addr_y) && (we_x || we_y);
  endfunction

  logic [1:0] ptr;
  logic [1:0] ptr_next;
  logic [1:0] cand;
  logic [1:0] idx_a;
  logic [1:0] idx_b;
  logic       hit_a;
  logic       hit_b;

  logic       tag_v1_a, tag_v2_a, tag_v1_b, tag_v2_b;
  logic [1:0] tag_id1_a, tag_id2_a, tag_id1_b, tag_id2_b;

  // Scan from ptr: first requester takes port A, next non-conflicting one takes port B.
  always_comb begin
    cand  = 2'd0;
    idx_a = 2'd0;
    idx_b = 2'd0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (req[cand] && !hit_a) begin
        hit_a = 1'b1;
        idx_a = cand;
      end else if (req[cand] && !hit_b &&
                   !conflict(addr[idx_a*AW +: AW], we[idx_a], addr[cand*AW +: AW], we[cand])) begin
        hit_b = 1'b1;
        idx_b = cand;
      end else begin
        idx_b = idx_b;
      end
    end
  end

  // Grant vector and round-robin pointer advance.
  always_comb begin
    gnt      = 4'b0000;
    ptr_next = ptr;
    if (!rst_n) begin
      gnt = 4'b0000;
    end else begin
      gnt = (hit_a ? (4'b0001 << idx_a) : 4'b0000) | (hit_b ? (4'b0001 << idx_b) : 4'b0000);
    end
    if (hit_b) begin
      ptr_next = idx_b + 2'd1;
    end else if (hit_a) begin
      ptr_next = idx_a + 2'd1;
    end else begin
      ptr_next = ptr;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else begin
      ptr <= ptr_next;
    end
  end

  // Port A command register; address and data hold when the port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en_a <= 1'b0;
      ram_addr_a  <= '0;
      ram_in_a    <= '0;
    end else if (hit_a) begin
      ram_wr_en_a <= we[idx_a];
      ram_addr_a  <= addr[idx_a*AW +: AW];
      ram_in_a    <= wdata[idx_a*DW +: DW];
    end else begin
      ram_wr_en_a <= 1'b0;
    end
  end

  // Port B command register; address and data hold when the port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en_b <= 1'b0;
      ram_addr_b  <= '0;
      ram_in_b    <= '0;
    end else if (hit_b) begin
      ram_wr_en_b <= we[idx_b];
      ram_addr_b  <= addr[idx_b*AW +: AW];
      ram_in_b    <= wdata[idx_b*DW +: DW];
    end else begin
      ram_wr_en_b <= 1'b0;
    end
  end

  // Read tags follow each port command through the RAM's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v1_a  <= 1'b0;
      tag_id1_a <= 2'd0;
      tag_v2_a  <= 1'b0;
      tag_id2_a <= 2'd0;
      tag_v1_b  <= 1'b0;
      tag_id1_b <= 2'd0;
      tag_v2_b  <= 1'b0;
      tag_id2_b <= 2'd0;
    end else begin
      tag_v1_a  <= hit_a && !we[idx_a];
      tag_id1_a <= idx_a;
      tag_v2_a  <= tag_v1_a;
      tag_id2_a <= tag_id1_a;
      tag_v1_b  <= hit_b && !we[idx_b];
      tag_id1_b <= idx_b;
      tag_v2_b  <= tag_v1_b;
      tag_id2_b <= tag_id1_b;
    end
  end

  // Return stage: steer each port's read data to the requester named by its tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 4'b0000;
      rdata  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (tag_v2_a && (tag_id2_a == 2'(i))) begin
          rvalid[i]           <= 1'b1;
          rdata[i*DW +: DW]   <= ram_out_a;
        end else if (tag_v2_b && (tag_id2_b == 2'(i))) begin
          rvalid[i]           <= 1'b1;
          rdata[i*DW +: DW]   <= ram_out_b;
        end else begin
          rvalid[i]           <= 1'b0;
        end
      end
    end
  end

endmodule
